// File: rtl/mem_step_sequencer.sv
// mem_step_sequencer: Moore control-step sequencer for ld/ldi/st.
// Steps fetch T0-T2, decode T3 and execute T4-T7. Memory steps stall on mem_ready.
// Ports: clock and clear (sync, active-low), run, ir_opcode and mem_ready in.
// Out: datapath enables, step (IDLE=0, T0..T7=1..8, FAULT=15), busy,
// instr_done, fault and timeout.
// Build option: SEQ_STORE_EN compiles in the st path (Write/Rout driven).
module mem_step_sequencer #(
  parameter int unsigned OPCODE_W = 5,
  parameter logic [OPCODE_W-1:0] OP_LD  = 5'b00000,
  parameter logic [OPCODE_W-1:0] OP_LDI = 5'b00001,
  parameter logic [OPCODE_W-1:0] OP_ST  = 5'b00010,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic PCout,
  output logic MARin,
  output logic IncPC,
  output logic Zlowin,
  output logic Zlowout,
  output logic PCin,
  output logic Read,
  output logic Write,
  output logic MDRin,
  output logic MDRout,
  output logic IRin,
  output logic Gra,
  output logic Grb,
  output logic BAout,
  output logic Rin,
  output logic Rout,
  output logic Yin,
  output logic Csignout,
  output logic ADD,
  output logic [3:0] step,
  output logic busy,
  output logic instr_done,
  output logic fault,
  output logic timeout
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    T0    = 4'd1,
    T1    = 4'd2,
    T2    = 4'd3,
    T3    = 4'd4,
    T4    = 4'd5,
    T5    = 4'd6,
    T6    = 4'd7,
    T7    = 4'd8,
    FAULT = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    K_LD  = 2'd0,
    K_LDI = 2'd1,
    K_ST  = 2'd2
  } kind_t;

  state_t     state;
  kind_t      kind;
  logic [7:0] wait_cnt;
  logic       fault_q;
  logic       timeout_q;

  logic is_mem;
  logic stall;
  logic expire;
  logic last;

  // Opcode class is captured at T3 so later steps do not depend on IR.
  always_comb begin
    is_mem = (state == T1) ||
             (state == T6 && kind == K_LD) ||
             (state == T7 && kind == K_ST);
    stall  = is_mem && !mem_ready;
    expire = stall && (wait_cnt == 8'(MAX_WAIT));
    last   = (state == T5 && kind == K_LDI) ||
             (state == T7 && kind == K_LD) ||
             (state == T7 && kind == K_ST && mem_ready);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      kind      <= K_LD;
      wait_cnt  <= 8'd0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (expire) begin
      state     <= FAULT;
      wait_cnt  <= 8'd0;
      fault_q   <= 1'b1;
      timeout_q <= 1'b1;
    end else if (stall) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
      if (last) begin
        state <= run ? T0 : IDLE;
      end else begin
        unique case (state)
          IDLE: if (run) state <= T0;
          T0:   state <= T1;
          T1:   state <= T2;
          T2:   state <= T3;
          T3: begin
            unique case (1'b1)
              (ir_opcode == OP_LD): begin
                kind  <= K_LD;
                state <= T4;
              end
              (ir_opcode == OP_LDI): begin
                kind  <= K_LDI;
                state <= T4;
              end
`ifdef SEQ_STORE_EN
              (ir_opcode == OP_ST): begin
                kind  <= K_ST;
                state <= T4;
              end
`endif
              default: begin
                state   <= FAULT;
                fault_q <= 1'b1;
              end
            endcase
          end
          T4:    state <= T5;
          T5:    state <= T6;
          T6:    state <= T7;
          T7:    state <= T7;
          FAULT: state <= FAULT;
          default: begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zlowin   = 1'b0;
    Zlowout  = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    BAout    = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    Yin      = 1'b0;
    Csignout = 1'b0;
    ADD      = 1'b0;
    unique case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        // PC update happens once even if the read stalls.
        Zlowout = (wait_cnt == 8'd0);
        PCin    = (wait_cnt == 8'd0);
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      T4: begin
        Csignout = 1'b1;
        ADD      = 1'b1;
        Zlowin   = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
        Gra     = (kind == K_LDI);
        Rin     = (kind == K_LDI);
        MARin   = (kind != K_LDI);
      end
      T6: begin
        MDRin = 1'b1;
        Read  = (kind == K_LD);
        Gra   = (kind == K_ST);
`ifdef SEQ_STORE_EN
        Rout  = (kind == K_ST);
`endif
      end
      T7: begin
        MDRout = (kind == K_LD);
        Gra    = (kind == K_LD);
        Rin    = (kind == K_LD);
`ifdef SEQ_STORE_EN
        Write  = (kind == K_ST);
`endif
      end
      default: ;
    endcase
  end

  assign step       = state;
  assign busy       = (state != IDLE) && (state != FAULT);
  assign instr_done = last;
  assign fault      = fault_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_mem_step_sequencer.sv
// tb_mem_step_sequencer: random instruction streams against a per-instruction
// step-trace model; compares step, enables and flags every cycle.
module tb_mem_step_sequencer;

  localparam int MW = 15;
`ifdef SEQ_STORE_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam logic [18:0] PCOUT  = 19'd1 << 18;
  localparam logic [18:0] MARIN  = 19'd1 << 17;
  localparam logic [18:0] INCPC  = 19'd1 << 16;
  localparam logic [18:0] ZLI    = 19'd1 << 15;
  localparam logic [18:0] ZLO    = 19'd1 << 14;
  localparam logic [18:0] PCIN   = 19'd1 << 13;
  localparam logic [18:0] READ   = 19'd1 << 12;
  localparam logic [18:0] WRITE  = 19'd1 << 11;
  localparam logic [18:0] MDRIN  = 19'd1 << 10;
  localparam logic [18:0] MDROUT = 19'd1 << 9;
  localparam logic [18:0] IRIN   = 19'd1 << 8;
  localparam logic [18:0] GRA    = 19'd1 << 7;
  localparam logic [18:0] GRB    = 19'd1 << 6;
  localparam logic [18:0] BAOUT  = 19'd1 << 5;
  localparam logic [18:0] RIN    = 19'd1 << 4;
  localparam logic [18:0] ROUT   = 19'd1 << 3;
  localparam logic [18:0] YIN    = 19'd1 << 2;
  localparam logic [18:0] CSIGN  = 19'd1 << 1;
  localparam logic [18:0] ADDM   = 19'd1;

  logic clock, clear, run, mem_ready;
  logic [4:0] ir_opcode;
  logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, Write, MDRin;
  logic MDRout, IRin, Gra, Grb, BAout, Rin, Rout, Yin, Csignout, ADD;
  logic [3:0] step;
  logic busy, instr_done, fault, timeout;
  logic [18:0] en_v;

  assign en_v = {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, Write,
                 MDRin, MDRout, IRin, Gra, Grb, BAout, Rin, Rout, Yin,
                 Csignout, ADD};

  mem_step_sequencer #(
    .OPCODE_W(5), .OP_LD(OP_LD), .OP_LDI(OP_LDI), .OP_ST(OP_ST),
    .MAX_WAIT(MW)
  ) dut (
    .clock(clock), .clear(clear), .run(run), .ir_opcode(ir_opcode),
    .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin),
    .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .Write(Write),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb),
    .BAout(BAout), .Rin(Rin), .Rout(Rout), .Yin(Yin),
    .Csignout(Csignout), .ADD(ADD),
    .step(step), .busy(busy), .instr_done(instr_done),
    .fault(fault), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic        run;
    logic        rdy;
    logic [4:0]  op;
    logic [3:0]  step;
    logic [18:0] en;
    logic        done;
    logic        busy;
    logic        flt;
    logic        tmo;
  } cyc_t;

  cyc_t q[$];
  logic tmo_m = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [18:0] e,
                      input logic d, input logic r, input logic [4:0] op);
    cyc_t c;
    c.clr  = 1'b1;
    c.run  = 1'($urandom % 2);
    c.rdy  = r;
    c.op   = op;
    c.step = st;
    c.en   = e;
    c.done = d;
    c.busy = (st != 4'd0) && (st != 4'd15);
    c.flt  = (st == 4'd15);
    c.tmo  = tmo_m;
    q.push_back(c);
  endtask

  // One memory step: s stall cycles then ready; s > MW times out.
  task automatic mem_step(input logic [3:0] st, input logic [18:0] e0,
                          input logic [18:0] e, input int s,
                          input bit fin, input logic [4:0] op,
                          output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= MW; k++) begin
      bit r;
      r = (k == s);
      push(st, (k == 0) ? e0 : e, fin && r, r, op);
      if (r) begin
        ok = 1'b1;
        return;
      end
    end
    tmo_m = 1'b1;
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom % 10);
    if (r < 6) return int'($urandom % 3);
    if (r < 8) return MW;
    if (r == 8) return MW + 1;
    return int'($urandom % 6);
  endfunction

  task automatic push_idle(input logic rn);
    push(4'd0, 19'd0, 1'b0, 1'($urandom % 2), 5'($urandom));
    q[q.size()-1].run = rn;
  endtask

  task automatic gen_instr();
    int sel, s1, s2, base, n, j;
    logic [4:0] op, junk;
    bit ok, legal, rn;
    sel  = int'($urandom % 8);
    junk = 5'($urandom);
    if (sel < 3)      op = OP_LD;
    else if (sel < 5) op = OP_LDI;
    else if (sel < 7) op = OP_ST;
    else              op = 5'(3 + $urandom % 29);
    legal = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST && ST_EN);
    s1 = pick();
    s2 = pick();
    base = q.size();
    push(4'd1, PCOUT | MARIN | INCPC | ZLI, 1'b0, 1'($urandom), junk);
    mem_step(4'd2, READ | MDRIN | ZLO | PCIN, READ | MDRIN, s1, 1'b0,
             junk, ok);
    if (ok) begin
      push(4'd3, MDROUT | IRIN, 1'b0, 1'($urandom), junk);
      push(4'd4, GRB | BAOUT | YIN, 1'b0, 1'($urandom), op);
      if (legal) begin
        push(4'd5, CSIGN | ADDM | ZLI, 1'b0, 1'($urandom), op);
        if (op == OP_LDI) begin
          push(4'd6, ZLO | GRA | RIN, 1'b1, 1'($urandom), op);
        end else begin
          push(4'd6, ZLO | MARIN, 1'b0, 1'($urandom), op);
          if (op == OP_LD) begin
            mem_step(4'd7, READ | MDRIN, READ | MDRIN, s2, 1'b0, op, ok);
            if (ok) push(4'd8, MDROUT | GRA | RIN, 1'b1, 1'($urandom), op);
          end else begin
            push(4'd7, GRA | ROUT | MDRIN, 1'b0, 1'($urandom), op);
            mem_step(4'd8, WRITE, WRITE, s2, 1'b1, op, ok);
          end
        end
      end
      ok = ok && legal;
    end
    if (!ok) begin
      n = 1 + int'($urandom % 3);
      for (int i = 0; i < n; i++) push(4'd15, 19'd0, 1'b0, 1'($urandom), op);
      q[q.size()-1].clr = 1'b0;
      tmo_m = 1'b0;
      push_idle(1'b1);
    end else if ($urandom % 8 == 0) begin
      j = base + int'($urandom % (q.size() - base));
      while (q.size() > j + 1) void'(q.pop_back());
      q[j].clr = 1'b0;
      push_idle(1'b1);
    end else begin
      rn = ($urandom % 3) != 0;
      q[q.size()-1].run = rn;
      if (!rn) begin
        n = int'($urandom % 3);
        for (int i = 0; i < n; i++) push_idle(1'b0);
        push_idle(1'b1);
      end
    end
  endtask

  initial begin
    cyc_t c;
    clear = 1'b0;
    run = 1'b1;
    ir_opcode = 5'd0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_step", 32'(step), 32'd0);
    check("rst_en", 32'(en_v), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(instr_done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_tmo", 32'(timeout), 32'd0);
    push_idle(1'b1);
    for (int i = 0; i < 80; i++) gen_instr();
    foreach (q[i]) begin
      c = q[i];
      cyc = i;
      check("step", 32'(step), 32'(c.step));
      check("en", 32'(en_v), 32'(c.en));
      check("done", 32'(instr_done), 32'(c.done));
      check("busy", 32'(busy), 32'(c.busy));
      check("fault", 32'(fault), 32'(c.flt));
      check("timeout", 32'(timeout), 32'(c.tmo));
      clear = c.clr;
      run = c.run;
      mem_ready = c.rdy;
      ir_opcode = c.op;
      @(negedge clock);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_step_sequencer.md
# mem_step_sequencer

Parametrised control-step sequencer that drives the datapath's register-transfer enables for the memory-class instructions `ld`, `ldi` and `st`. It is a Moore FSM that steps through fetch (T0–T2), decode, and execute (T3–T7). It sits between the IR opcode field and the datapath control inputs, replacing hand-timed stimulus. Unlike fixed-timing control, memory steps stall on a `mem_ready` handshake, with a configurable timeout.

## Interface
Parameters:
- `OPCODE_W`, default 5: width of `ir_opcode`.
- `OP_LD`, default 5'b00000: opcode of `ld`.
- `OP_LDI`, default 5'b00001: opcode of `ldi`.
- `OP_ST`, default 5'b00010: opcode of `st`.
- `MAX_WAIT`, default 15: maximum stall cycles in one memory step before a fault; legal range 1–255.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `clear` in 1: reset, synchronous, active-low.
- `run` in 1: start or continue sequencing.
- `ir_opcode` in OPCODE_W: IR[31:27]; valid from T3 onward.
- `mem_ready` in 1: memory completes the current Read/Write this cycle.
- `PCout`, `MARin`, `IncPC`, `Zlowin`, `Zlowout`, `PCin`, `Read`, `Write`, `MDRin`, `MDRout`, `IRin`, `Gra`, `Grb`, `BAout`, `Rin`, `Rout`, `Yin`, `Csignout`, `ADD` out 1 each: datapath control enables.
- `step` out 4: current step. IDLE=0, T0..T7=1..8, FAULT=15.
- `busy` out 1: high in any state other than IDLE and FAULT.
- `instr_done` out 1: high during the final step of an instruction.
- `fault` out 1: sticky error flag.
- `timeout` out 1: sticky error flag.

## Operation
- All outputs are decoded combinationally from registered state. They are therefore glitch-free and stable for whole cycles. Any enable not listed for a state is 0.
- IDLE:
  - Go to T0 when `run`=1.
- Fetch steps:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1 (memory step): Read and MDRin in every cycle. Zlowout and PCin only in the first cycle (`wait_cnt`=0). Go to T2 in the cycle `mem_ready`=1.
  - T2: MDRout, IRin.
- T3: Grb, BAout, Yin. Decode `ir_opcode` here:
  - An unknown opcode goes to FAULT instead of T4.
  - `st` also goes to FAULT when SEQ_STORE_EN is undefined.
- T4: Csignout, ADD, Zlowin.
- T5, by opcode:
  - `ldi`: Zlowout, Gra, Rin, `instr_done`. This is the last step.
  - `ld`/`st`: Zlowout, MARin.
- T6, by opcode:
  - `ld` (memory step): Read, MDRin. Go to T7 on `mem_ready`.
  - `st`: Gra, Rout, MDRin (Read=0, so MDR loads from the bus). One cycle.
- T7, by opcode:
  - `ld`: MDRout, Gra, Rin, `instr_done`.
  - `st` (memory step): Write held until `mem_ready`; `instr_done` in the `mem_ready` cycle.
- After the last step, go to T0 if `run`=1, else to IDLE.
- Stall counter (`wait_cnt`, 8 bits):
  - Increments each cycle a memory step holds with `mem_ready`=0.
  - Clears on leaving any state.
  - When `wait_cnt`=MAX_WAIT and `mem_ready`=0, go to FAULT and set `timeout`.
- FAULT:
  - All enables 0, `fault`=1.
  - FAULT is left only by `clear`; `run` is ignored.
- `run` is sampled only in IDLE and at the last step. Dropping `run` mid-instruction does not abort it.

## Timing
- Reset: when `clear`=0 at a rising edge:
  - state goes to IDLE; `wait_cnt`, `fault` and `timeout` go to 0.
  - In the following cycle every output is 0 and `step`=0.
  - This overrides everything else, including mid-instruction and mid-Write; the aborted Write is dropped.
- Latency from `run` sampled high in IDLE to T0 is 1 cycle.
- Zero-wait memory (`mem_ready` tied high): `ld` = 8 cycles, `st` = 8 cycles, `ldi` = 6 cycles. Each memory step adds one cycle per stall.
- Back-to-back instructions: T0 follows the last step with no idle cycle.
- `mem_ready`=1 arriving in a non-memory step is ignored.
- `mem_ready`=1 in the same cycle that `wait_cnt` reaches MAX_WAIT counts as completion, not timeout.

## Configuration
- `SEQ_STORE_EN`:
  - Defined: the `st` path through T5–T7 is compiled in, and the `Write` and `Rout` outputs are driven.
  - Undefined: `st` decodes as illegal at T3 and goes to FAULT; `Write` and `Rout` are tied to 0.

## Test plan
- Reset: hold `clear`=0 for 2 cycles with `run`=1 → every output 0 and `step`=0. Release `clear` → `step`=1 one cycle later.
- `ld` (opcode 00000), `mem_ready`=1 → `step` runs 1..8. MARin is high at steps 1 and 6. Rin is high only at step 8, together with `instr_done`. `busy` is high for 8 cycles.
- `ldi` (opcode 00001) with `run` held high → done at step 6, then step 1 on the next cycle. Read is never asserted after T2.
- `ld` with `mem_ready` low for 3 cycles in T6 → Read and MDRin high for 4 cycles, total 11 cycles, `timeout`=0.
- `st` (opcode 00010), SEQ_STORE_EN defined, `mem_ready` low for MAX_WAIT+1 cycles in T7 → `step`=15, `fault`=1, `timeout`=1, Write=0 after the fault. Then `clear` → IDLE.
- Opcode 11111 → FAULT at the cycle after T3, `timeout`=0. Repeat `st` with SEQ_STORE_EN undefined → same result.
